// File: rtl/uart_cmd_responder_pkg.sv
// Shared command codes, reply bytes and FSM state encoding for the UART
// command responder.
package uart_cmd_responder_pkg;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'hAA;
    localparam logic [7:0] NAK    = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_EXEC,
        S_RD_WAIT,
        S_TX_BYTE,
        S_TX_WAIT
    } state_t;

endpackage

// File: rtl/uart_cmd_responder_byte_timeout.sv
// Inter-byte timeout: counts enabled cycles since the last clear and pulses
// expired once when the count reaches LIMIT; the count saturates there.
module uart_byte_timeout #(
    parameter logic [23:0] LIMIT = 24'd999_999
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [23:0] count;
    logic        fired;

    // A clear in the same cycle wins, so a byte arriving at expiry is kept.
    assign expired = enable && !clear && !fired && (count == LIMIT);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count <= '0;
            fired <= 1'b0;
        end else if (clear) begin
            count <= '0;
            fired <= 1'b0;
        end else if (enable) begin
            if (count != LIMIT) count <= count + 24'd1;
            if (expired) fired <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-framed register access over a UART: parses SOF/CMD/ADDR/[DATA]/CHK
// frames, performs the register write or read, and sends an ACK/NAK reply.
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter logic [7:0]  SOF            = 8'h55,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_send,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err,
    output logic [3:0] dbg_state
);

    // Handshakes: rx_valid is a one-cycle strobe, always consumed or dropped;
    // tx_send fires only while tx_ready=1, and the next byte waits for
    // tx_ready to fall and rise again.
    state_t     state, state_nx;
    logic [7:0] cmd_q, chk_acc, rdata_q;
    logic       chk_ok_q, seen_low_q;
    logic [1:0] tx_idx;
    logic       in_frame, expired, ok_wr, ok_rd, last_byte;

    assign in_frame  = (state inside {S_CMD, S_ADDR, S_DATA, S_CHK});
    assign ok_wr     = chk_ok_q && (cmd_q == CMD_WR);
    assign ok_rd     = chk_ok_q && (cmd_q == CMD_RD);
    assign last_byte = !ok_rd || (tx_idx == 2'd3);
    assign dbg_state = state;

    uart_byte_timeout #(
        .LIMIT(TIMEOUT_CYCLES - 24'd1)
    ) u_timeout (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (rx_valid || (state == S_IDLE)),
        .enable (in_frame),
        .expired(expired)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        tx_send   = 1'b0;
        frame_err = 1'b0;
        case (state)
            S_IDLE:    if (rx_valid && rx_data == SOF) state_nx = S_CMD;
            S_CMD:     if (rx_valid) state_nx = S_ADDR;
            S_ADDR:    if (rx_valid) state_nx = (cmd_q == CMD_WR) ? S_DATA : S_CHK;
            S_DATA:    if (rx_valid) state_nx = S_CHK;
            S_CHK:     if (rx_valid) state_nx = S_EXEC;
            S_EXEC: begin
                if (ok_wr) begin
                    reg_we   = 1'b1;
                    state_nx = S_TX_BYTE;
                end else if (ok_rd) begin
                    reg_re   = 1'b1;
                    state_nx = S_RD_WAIT;
                end else begin
                    frame_err = 1'b1;
                    state_nx  = S_TX_BYTE;
                end
            end
            S_RD_WAIT: state_nx = S_TX_BYTE;
            S_TX_BYTE: begin
                if (tx_ready) begin
                    tx_send  = 1'b1;
                    state_nx = S_TX_WAIT;
                end
            end
            S_TX_WAIT: if (seen_low_q && tx_ready) state_nx = last_byte ? S_IDLE : S_TX_BYTE;
            default:   state_nx = S_IDLE;
        endcase
        if (in_frame && !rx_valid && expired) begin
            state_nx  = S_IDLE;
            frame_err = 1'b1;
        end
        // Bytes arriving while a frame is executing or replying are lost.
        if (rx_valid && !in_frame && state != S_IDLE) frame_err = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cmd_q      <= '0;
            chk_acc    <= '0;
            chk_ok_q   <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            rdata_q    <= '0;
            tx_data    <= '0;
            tx_idx     <= '0;
            seen_low_q <= 1'b0;
        end else begin
            if (rx_valid) begin
                case (state)
                    S_IDLE: if (rx_data == SOF) chk_acc <= '0;
                    S_CMD: begin
                        cmd_q   <= rx_data;
                        chk_acc <= chk_acc ^ rx_data;
                    end
                    S_ADDR: begin
                        reg_addr <= rx_data;
                        chk_acc  <= chk_acc ^ rx_data;
                    end
                    S_DATA: begin
                        reg_wdata <= rx_data;
                        chk_acc   <= chk_acc ^ rx_data;
                    end
                    S_CHK:   chk_ok_q <= (chk_acc == rx_data);
                    default: ;
                endcase
            end
            if (state == S_EXEC) begin
                tx_idx <= '0;
                if (!ok_rd) tx_data <= ok_wr ? ACK : NAK;
            end
            if (state == S_RD_WAIT) begin
                rdata_q <= reg_rdata;
                tx_data <= ACK;
            end
            if (tx_send) begin
                tx_idx     <= tx_idx + 2'd1;
                seen_low_q <= 1'b0;
            end
            if (state == S_TX_WAIT && !tx_ready) seen_low_q <= 1'b1;
            // Read reply tail: data byte, then data^ACK.
            if (state == S_TX_WAIT && state_nx == S_TX_BYTE)
                tx_data <= (tx_idx == 2'd1) ? rdata_q : (rdata_q ^ ACK);
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: frames in, register strobes and
// reply bytes observed against hand-computed expectations.
module tb_uart_cmd_responder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, frame_err;
    logic [3:0] dbg_state;

    uart_cmd_responder #(
        .SOF(8'h55),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_send(tx_send),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .frame_err(frame_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int we_n, re_n, both_n, viol_n, err_n, err_cyc, first_tx_cyc, last_rx_cyc;
    logic [7:0] we_addr, we_data, re_addr;
    logic [7:0] rd_value = 8'h5A;

    task automatic clear_logs();
        we_n = 0; re_n = 0; both_n = 0; viol_n = 0; err_n = 0;
        err_cyc = -1; first_tx_cyc = -1;
        got_q.delete();
        exp_q.delete();
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (reg_we) begin we_n++; we_addr = reg_addr; we_data = reg_wdata; end
            if (reg_re) begin re_n++; re_addr = reg_addr; end
            if (reg_we && reg_re) both_n++;
            if (tx_send && !tx_ready) viol_n++;
            if (tx_send) begin
                if (got_q.size() == 0) first_tx_cyc = cyc;
                got_q.push_back(tx_data);
            end
            if (frame_err) begin err_n++; err_cyc = cyc; end
        end
    end

    // UART transmitter model: busy for 4 cycles after each tx_send
    initial begin
        logic saw;
        int   busy;
        tx_ready = 1'b1;
        busy = 0;
        forever begin
            @(negedge clk_in);
            saw = tx_send;
            @(posedge clk_in);
            #1;
            if (saw) begin
                busy = 4;
                tx_ready = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) tx_ready = 1'b1;
            end
        end
    end

    // register file model: read data valid only the cycle after reg_re
    initial begin
        logic saw_re;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk_in);
            saw_re = reg_re;
            @(posedge clk_in);
            #1;
            reg_rdata = saw_re ? rd_value : 8'h00;
        end
    end

    // driver tasks (called at posedge+1)
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        last_rx_cyc = cyc;
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'h55); send_byte(8'h01); send_byte(a); send_byte(d); send_byte(c);
    endtask

    task automatic send_rd(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] c);
        send_byte(8'h55); send_byte(cmd); send_byte(a); send_byte(c);
    endtask

    task automatic wait_idle(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_in);
            if (dbg_state == 4'd0 && tx_ready) done = 1'b1;
        end
        check_val({tag, "_reached_idle"}, done, 1'b1);
        idle(2);
    endtask

    task automatic wait_tx(input string tag, input int n);
        logic done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_in);
            if (got_q.size() >= n) done = 1'b1;
        end
        check_val({tag, "_tx_seen"}, done, 1'b1);
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_tx(input string tag);
        check_val({tag, "_tx_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val($sformatf("%s_tx%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        int k;
        rst_in = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        clear_logs();
        #12;
        check_val("rst_tx_send", tx_send, 1'b0);
        check_val("rst_tx_data", tx_data, 8'h00);
        check_val("rst_reg_we", reg_we, 1'b0);
        check_val("rst_reg_re", reg_re, 1'b0);
        check_val("rst_reg_addr", reg_addr, 8'h00);
        check_val("rst_reg_wdata", reg_wdata, 8'h00);
        check_val("rst_frame_err", frame_err, 1'b0);
        check_val("rst_state", dbg_state, 4'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        idle(2);

        // noise then write
        clear_logs();
        send_byte(8'h00); send_byte(8'hFF);
        send_wr(8'h10, 8'h3C, 8'h2D);
        k = last_rx_cyc;
        wait_idle("wr");
        exp_q.push_back(8'hAA);
        check_tx("wr");
        check_val("wr_we_n", we_n, 1);
        check_val("wr_addr", we_addr, 8'h10);
        check_val("wr_data", we_data, 8'h3C);
        check_val("wr_re_n", re_n, 0);
        check_val("wr_err_n", err_n, 0);
        check_val("wr_latency", first_tx_cyc - k, 2);

        // read
        clear_logs();
        send_rd(8'h02, 8'h20, 8'h22);
        k = last_rx_cyc;
        wait_idle("rd");
        exp_q.push_back(8'hAA); exp_q.push_back(8'h5A); exp_q.push_back(8'hF0);
        check_tx("rd");
        check_val("rd_re_n", re_n, 1);
        check_val("rd_addr", re_addr, 8'h20);
        check_val("rd_we_n", we_n, 0);
        check_val("rd_err_n", err_n, 0);
        check_val("rd_latency", first_tx_cyc - k, 3);
        check_val("rd_send_while_busy", viol_n, 0);

        // bad checksum
        clear_logs();
        send_wr(8'h10, 8'h3C, 8'h00);
        wait_idle("badchk");
        exp_q.push_back(8'hEE);
        check_tx("badchk");
        check_val("badchk_we_n", we_n, 0);
        check_val("badchk_err_n", err_n, 1);

        // unknown command, parsed as a read-length frame
        clear_logs();
        send_rd(8'h07, 8'h10, 8'h17);
        k = last_rx_cyc;
        wait_idle("unk");
        exp_q.push_back(8'hEE);
        check_tx("unk");
        check_val("unk_we_re", we_n + re_n, 0);
        check_val("unk_err_n", err_n, 1);
        check_val("unk_latency", first_tx_cyc - k, 2);

        // timeout after 55 01
        clear_logs();
        send_byte(8'h55); send_byte(8'h01);
        k = last_rx_cyc;
        idle(130);
        check_val("to_err_n", err_n, 1);
        check_val("to_err_cycle", err_cyc - k, 100);
        check_val("to_tx_count", got_q.size(), 0);
        check_val("to_state", dbg_state, 4'd0);

        // byte arriving on the expiry cycle is accepted
        clear_logs();
        send_byte(8'h55); send_byte(8'h01);
        idle(99);
        send_byte(8'h10); send_byte(8'h3C); send_byte(8'h2D);
        wait_idle("edge");
        exp_q.push_back(8'hAA);
        check_tx("edge");
        check_val("edge_err_n", err_n, 0);
        check_val("edge_we_n", we_n, 1);

        // valid frame after timeout
        clear_logs();
        send_wr(8'h44, 8'h99, 8'hDC);
        wait_idle("post_to");
        exp_q.push_back(8'hAA);
        check_tx("post_to");
        check_val("post_to_addr", we_addr, 8'h44);
        check_val("post_to_data", we_data, 8'h99);

        // byte injected during a read reply
        clear_logs();
        rd_value = 8'h5A;
        send_rd(8'h02, 8'h20, 8'h22);
        wait_tx("inj", 1);
        send_byte(8'h55);
        wait_idle("inj");
        exp_q.push_back(8'hAA); exp_q.push_back(8'h5A); exp_q.push_back(8'hF0);
        check_tx("inj");
        check_val("inj_err_n", err_n, 1);
        check_val("inj_re_n", re_n, 1);

        // reset in the middle of a read reply
        clear_logs();
        send_rd(8'h02, 8'h20, 8'h22);
        wait_tx("mid", 1);
        rst_in = 1'b1;
        #1;
        check_val("mid_rst_state", dbg_state, 4'd0);
        check_val("mid_rst_tx_data", tx_data, 8'h00);
        check_val("mid_rst_reg_addr", reg_addr, 8'h00);
        check_val("mid_rst_tx_send", tx_send, 1'b0);
        idle(2);
        rst_in = 1'b0;
        idle(10);
        check_val("mid_abandon", got_q.size(), 1);
        clear_logs();
        send_wr(8'h10, 8'h3C, 8'h2D);
        wait_idle("after_rst");
        exp_q.push_back(8'hAA);
        check_tx("after_rst");
        check_val("after_rst_we_n", we_n, 1);
        check_val("after_rst_err_n", err_n, 0);
        check_val("never_we_and_re", both_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter SOF, default 8'h55: start-of-frame byte.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd1_000_000: maximum clk_in cycles allowed between bytes inside a frame.
REQ-003 clk_in  input  1  clock.
REQ-004 rst_in  input  1  reset; asynchronous, active-high.
REQ-005 rx_data  input  8  byte from the UART receiver; valid when rx_valid=1.
REQ-006 rx_valid  input  1  one-cycle strobe for each received byte.
REQ-007 tx_ready  input  1  UART transmitter idle; it deasserts the cycle after tx_send.
REQ-008 tx_data  output  8  reply byte; held stable while tx_send=1.
REQ-009 tx_send  output  1  one-cycle strobe that starts transmission of tx_data.
REQ-010 reg_addr  output  8  register address.
REQ-011 reg_wdata  output  8  register write data.
REQ-012 reg_we  output  1  one-cycle write strobe.
REQ-013 reg_re  output  1  one-cycle read strobe.
REQ-014 reg_rdata  input  8  read data; valid exactly 1 cycle after reg_re.
REQ-015 frame_err  output  1  one-cycle pulse on a checksum error, unknown command, timeout or dropped byte.

Function
REQ-016 Request frames:
- Write: SOF, 0x01, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA.
- Read: SOF, 0x02, ADDR, CHK, where CHK = CMD^ADDR.
REQ-017 Receive states: IDLE -> CMD -> ADDR -> DATA (write only) -> CHK -> EXEC. Each transition occurs on rx_valid.
REQ-018 In IDLE, non-SOF bytes are discarded silently (no frame_err).
REQ-019 In the CMD state:
- 0x01 or 0x02: frame proceeds normally.
- Any other value: frame is parsed as a read-length frame (ADDR, CHK) and then NAKed.
REQ-020 Checksum accumulation:
- Running XOR, cleared on SOF.
- Compared against the CHK byte.
- Mismatch: no register access, NAK reply, frame_err pulse.
REQ-021 Valid write, in EXEC (the cycle after CHK is accepted):
- reg_we=1 for one cycle, with reg_addr/reg_wdata from the frame.
- Reply: 0xAA.
REQ-022 Valid read:
- reg_re=1 in EXEC.
- RD_WAIT captures reg_rdata on the next cycle.
- Reply: 0xAA, DATA, DATA^0xAA.
REQ-023 NAK reply: the single byte 0xEE.
REQ-024 TX handshake:
- tx_send is asserted only when tx_ready=1 in a TX_BYTE state.
- TX_WAIT then waits for tx_ready=0 and then tx_ready=1 before the next byte.
- After the last reply byte, the FSM returns to IDLE once tx_ready=1.
REQ-025 Inter-byte timeout:
- Counter cleared on every rx_valid.
- It counts only in CMD/ADDR/DATA/CHK.
- On reaching TIMEOUT_CYCLES-1: return to IDLE, frame_err pulse, no reply.
- The counter saturates and does not wrap.
REQ-026 rx_valid during EXEC/RD_WAIT/TX states: the byte is dropped and frame_err pulses; the reply is unaffected.
REQ-027 If rx_valid and timeout expiry occur in the same cycle, the byte is accepted and the timeout is ignored.
REQ-028 reg_we and reg_re are never asserted in the same cycle. Neither is asserted outside EXEC.
REQ-029 Latency from CHK rx_valid to first tx_send:
- 2 cycles for a write or NAK when tx_ready=1.
- 3 cycles for a read.

Reset
REQ-030 On rst_in=1, asynchronously:
- state=IDLE.
- tx_send=0, tx_data=0.
- reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0.
- frame_err=0.
- Timeout counter and checksum cleared.
REQ-031 Reset during a reply abandons the remaining bytes. A tx_send already issued is not retracted.
REQ-032 After rst_in deasserts, the first byte accepted is the next SOF.

Structure
REQ-033 A shared package holds:
- Command codes CMD_WR=8'h01, CMD_RD=8'h02.
- ACK=8'hAA, NAK=8'hEE.
- The FSM state enum.
REQ-034 The timeout counter is a sub-module named uart_byte_timeout, with inputs clear and enable and a one-cycle expired pulse. All other logic is a single FSM.

Verification
REQ-035 Write: 55 01 10 3C 2D -> reg_we once with addr 0x10, data 0x3C; tx sends AA; no frame_err.
REQ-036 Read: 55 02 20 22, reg_rdata=0x5A -> reg_re once with addr 0x20; tx sends AA 5A F0 in order, with no tx_send while tx_ready=0.
REQ-037 Bad checksum: 55 01 10 3C 00 -> no reg_we; tx sends EE; frame_err pulses once. Unknown command 55 07 10 17 -> EE.
REQ-038 Timeout: 55 01 then silence for TIMEOUT_CYCLES (test value 100) -> frame_err at cycle 99; no tx. A following valid frame is processed normally.
REQ-039 Noise/overlap:
- Bytes 00 FF before SOF -> ignored.
- A byte injected during the AA 5A F0 reply -> frame_err, reply intact.
- rst_in mid-reply -> outputs reset; next frame is OK.
